// File: rtl/figure_motion_ctrl_pkg.sv
// rtl/figure_motion_ctrl_pkg.sv - display constants and helpers shared by the VGA path
//
// Purpose: visible raster size, default figure size, 3-bit {R,G,B} colour
// codes, button lane indices and the per-axis step/clamp helper.
// Ports: none (package).

package figure_motion_ctrl_pkg;

  localparam int DISP_H_ACTIVE = 640;
  localparam int DISP_V_ACTIVE = 480;
  localparam int DISP_FIG_W    = 32;
  localparam int DISP_FIG_H    = 32;

  localparam int POS_W = 10;

  // Colour encoding is {R, G, B}; black is never shown as a figure colour.
  typedef logic [2:0] color_t;
  localparam color_t COLOR_BLACK   = 3'b000;
  localparam color_t COLOR_BLUE    = 3'b001;
  localparam color_t COLOR_GREEN   = 3'b010;
  localparam color_t COLOR_CYAN    = 3'b011;
  localparam color_t COLOR_RED     = 3'b100;
  localparam color_t COLOR_MAGENTA = 3'b101;
  localparam color_t COLOR_YELLOW  = 3'b110;
  localparam color_t COLOR_WHITE   = 3'b111;

  // Lane indices into the debounced button vector.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_COLOR = 4;
  localparam int NUM_BTN   = 5;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_e;

  // Opposing buttons pressed together cancel out.
  function automatic dir_e axis_dir(input logic inc, input logic dec);
    if (inc && !dec) return DIR_INC;
    if (dec && !inc) return DIR_DEC;
    return DIR_HOLD;
  endfunction

  // One frame of motion on one axis. The increment is formed one bit wider
  // than the position so a step near the top of the range clamps instead of
  // wrapping; the decrement saturates at zero.
  function automatic logic [POS_W-1:0] step_axis(
    input logic [POS_W-1:0] pos,
    input dir_e             dir,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] limit
  );
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    case (dir)
      DIR_INC: step_axis = (sum > {1'b0, limit}) ? limit : sum[POS_W-1:0];
      DIR_DEC: step_axis = (pos < step) ? '0 : pos - step;
      default: step_axis = pos;
    endcase
  endfunction

  // Cycle through the seven non-black colours: 1 -> 2 -> ... -> 7 -> 1.
  function automatic color_t next_color(input color_t c);
    return (c == COLOR_WHITE) ? COLOR_BLUE : c + 3'd1;
  endfunction

endpackage

// File: rtl/figure_motion_ctrl_btn_debounce.sv
// rtl/figure_motion_ctrl_btn_debounce.sv - pushbutton synchroniser and debouncer
//
// Purpose: brings one raw, asynchronous pushbutton into the clk domain and
// only accepts a level change after it has held for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk     in   pixel clock
//   rst     in   asynchronous active-high reset
//   btn_in  in   raw button, asynchronous to clk
//   btn_out out  debounced level (registered)

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_out
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync_q2 <= sync_q1;
    end
  end

  // Any sample that agrees with the accepted level restarts the count, so
  // only an unbroken run of disagreeing samples can flip the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_out <= 1'b0;
      cnt     <= '0;
    end else if (sync_q2 == btn_out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      btn_out <= ~btn_out;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/figure_motion_ctrl.sv
// rtl/figure_motion_ctrl.sv - per-frame figure position and colour from pushbuttons
//
// Purpose: debounces the five board buttons, detects the start of each
// vsync pulse and, on that edge only, moves the figure by STEP per axis
// (clamped to the visible area) and applies any pending colour advance.
// Ports:
//   clk                                  in   pixel clock (shared with sync generator)
//   rst                                  in   asynchronous active-high reset
//   btn_up/btn_down/btn_left/btn_right   in   raw direction buttons, active-high
//   btn_color                            in   raw colour-cycle button, active-high
//   vsync                                in   active-low vsync, synchronous to clk
//   pos_x, pos_y                         out  figure top-left corner
//   color                                out  figure {R,G,B}, never black
//   frame_tick                           out  one-cycle pulse at start of vsync

module figure_motion_ctrl
  import figure_motion_ctrl_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         STEP            = 4,
  parameter int         FIG_W           = DISP_FIG_W,
  parameter int         FIG_H           = DISP_FIG_H,
  parameter int         H_ACTIVE        = DISP_H_ACTIVE,
  parameter int         V_ACTIVE        = DISP_V_ACTIVE,
  parameter int         X_INIT          = 304,
  parameter int         Y_INIT          = 224,
  parameter logic [2:0] COLOR_INIT      = COLOR_RED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_color,
  input  logic             vsync,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [2:0]       color,
  output logic             frame_tick
);

  localparam logic [POS_W-1:0] STEP_V = POS_W'(STEP);
  localparam logic [POS_W-1:0] X_MAX  = POS_W'(H_ACTIVE - FIG_W);
  localparam logic [POS_W-1:0] Y_MAX  = POS_W'(V_ACTIVE - FIG_H);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_db;

  logic             vsync_d;
  logic             frame_start;
  logic             color_db_d;
  logic             color_rise;
  logic             color_pend;
  logic [POS_W-1:0] pos_x_nxt;
  logic [POS_W-1:0] pos_y_nxt;
  logic [2:0]       color_nxt;

  assign btn_raw = {btn_color, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_in  (btn_raw[i]),
      .btn_out (btn_db[i])
    );
  end

  // vsync_d resets high so a vsync already low when reset lifts still
  // counts as the start of a pulse.
  always_comb begin
    frame_start = vsync_d & ~vsync;
    color_rise  = btn_db[BTN_COLOR] & ~color_db_d;
    pos_x_nxt   = step_axis(pos_x, axis_dir(btn_db[BTN_RIGHT], btn_db[BTN_LEFT]), STEP_V, X_MAX);
    pos_y_nxt   = step_axis(pos_y, axis_dir(btn_db[BTN_DOWN], btn_db[BTN_UP]), STEP_V, Y_MAX);
    color_nxt   = color_pend ? next_color(color) : color;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
      color_db_d <= 1'b0;
      color_pend <= 1'b0;
      pos_x      <= POS_W'(X_INIT);
      pos_y      <= POS_W'(Y_INIT);
      color      <= COLOR_INIT;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= frame_start;
      color_db_d <= btn_db[BTN_COLOR];
      if (frame_start) begin
        pos_x <= pos_x_nxt;
        pos_y <= pos_y_nxt;
        color <= color_nxt;
        // A press landing on the frame edge itself is kept for the next frame.
        color_pend <= color_rise;
      end else if (color_rise) begin
        color_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_figure_motion_ctrl.sv
// tb/tb_figure_motion_ctrl.sv - self-checking bench for figure_motion_ctrl

module tb_figure_motion_ctrl;

  localparam int N     = 16;
  localparam int VPER  = 200;
  localparam int VLOW  = 4;
  localparam int STEP  = 4;
  localparam int XMAX  = 640 - 32;
  localparam int YMAX  = 480 - 32;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       vsync = 1'b1;
  logic [4:0] btn   = '0;   // 0 up, 1 down, 2 left, 3 right, 4 color
  logic [9:0] pos_x, pos_y;
  logic [2:0] color;
  logic       frame_tick;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  figure_motion_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn[0]),
    .btn_down   (btn[1]),
    .btn_left   (btn[2]),
    .btn_right  (btn[3]),
    .btn_color  (btn[4]),
    .vsync      (vsync),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .color      (color),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    int vc;
    vc = 0;
    forever begin
      @(negedge clk);
      vsync = (vc < VLOW) ? 1'b0 : 1'b1;
      vc = (vc + 1) % VPER;
    end
  end

  // Reference model: a button level is accepted once the raw input, seen
  // two cycles late, has disagreed with the accepted level for the last N
  // cycles, all of them after the previous acceptance.
  int m_x, m_y, m_col;
  bit m_tick, m_pend, m_vs_prev, m_col_prev;
  bit m_db[5];
  int m_since[5];
  bit m_hist[5][N+2];

  function automatic int move(int p, bit inc, bit dec, int lim);
    if (inc && !dec) return (p + STEP > lim) ? lim : p + STEP;
    if (dec && !inc) return (p < STEP) ? 0 : p - STEP;
    return p;
  endfunction

  task automatic model_reset();
    m_x = 304; m_y = 224; m_col = 4;
    m_tick = 0; m_pend = 0; m_vs_prev = 1; m_col_prev = 0;
    for (int b = 0; b < 5; b++) begin
      m_db[b] = 0;
      m_since[b] = 0;
      for (int i = 0; i < N + 2; i++) m_hist[b][i] = 0;
    end
  endtask

  task automatic model_step();
    bit fall, rise, all_diff;
    fall = m_vs_prev && !vsync;
    rise = m_db[4] && !m_col_prev;
    m_tick = fall;
    if (fall) begin
      m_x = move(m_x, m_db[3], m_db[2], XMAX);
      m_y = move(m_y, m_db[1], m_db[0], YMAX);
      if (m_pend) m_col = (m_col == 7) ? 1 : m_col + 1;
      m_pend = rise;
    end else if (rise) begin
      m_pend = 1;
    end
    m_col_prev = m_db[4];
    m_vs_prev = vsync;
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < N + 1; i++) m_hist[b][i] = m_hist[b][i+1];
      m_hist[b][N+1] = btn[b];
      m_since[b]++;
      all_diff = 1;
      for (int i = 0; i < N; i++) if (m_hist[b][i] == m_db[b]) all_diff = 0;
      if (all_diff && m_since[b] >= N) begin
        m_db[b] = !m_db[b];
        m_since[b] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        tests++;
        if (pos_x !== 10'(m_x) || pos_y !== 10'(m_y) || color !== 3'(m_col) || frame_tick !== m_tick) begin
          fails++;
          $display("FAIL model_cmp t=%0t: got x=%0d y=%0d col=%0d tick=%0b, expected x=%0d y=%0d col=%0d tick=%0b",
                   $time, pos_x, pos_y, color, frame_tick, m_x, m_y, m_col, m_tick);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 400);
    if (frame_tick !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL frame_tick_timeout: got no pulse in 400 cycles, expected one");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

  int exp_col[7] = '{5, 6, 7, 1, 2, 3, 4};

  initial begin
    cycles(4);
    rst = 1'b0;
    check("reset_x", pos_x, 304);
    check("reset_y", pos_y, 224);
    check("reset_color", color, 4);
    check("reset_tick", frame_tick, 0);
    chk_en = 1'b1;

    wait_tick();
    @(negedge clk);
    check("tick_width", frame_tick, 0);

    for (int i = 0; i < 5; i++) begin
      btn[3] = 1'b1; cycles(10);
      btn[3] = 1'b0; cycles(110);
    end
    check("glitch_x", pos_x, 304);

    wait_tick();
    btn[3] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_tick();
      check("right_step_x", pos_x, 304 + 4 * i);
    end

    btn[3] = 1'b0;
    btn[2] = 1'b1;
    repeat (100) wait_tick();
    check("left_clamp_x", pos_x, 0);
    btn[2] = 1'b0;

    btn[0] = 1'b1;
    btn[1] = 1'b1;
    repeat (3) wait_tick();
    check("updown_y", pos_y, 224);
    btn[0] = 1'b0;
    btn[1] = 1'b0;

    do_reset();
    wait_tick();
    btn[3] = 1'b1;
    repeat (75) wait_tick();
    check("right_604_x", pos_x, 604);
    repeat (10) wait_tick();
    check("right_clamp_x", pos_x, 608);
    btn[3] = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wait_tick();
      btn[4] = 1'b1; cycles(50);
      btn[4] = 1'b0;
      wait_tick();
      check("color_press", color, exp_col[i]);
    end

    wait_tick();
    btn[4] = 1'b1;
    repeat (10) wait_tick();
    btn[4] = 1'b0;
    cycles(30);
    check("color_held", color, 5);

    wait_tick();
    btn[4] = 1'b1; cycles(30);
    btn[4] = 1'b0; cycles(30);
    btn[4] = 1'b1; cycles(30);
    btn[4] = 1'b0;
    wait_tick();
    check("color_double", color, 6);
    wait_tick();
    check("color_double_hold", color, 6);

    do_reset();
    wait_tick();
    btn[3] = 1'b1;
    repeat (9) wait_tick();
    check("pre_reset_x", pos_x, 340);
    cycles(50);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset_x", pos_x, 304);
    check("async_reset_y", pos_y, 224);
    check("async_reset_color", color, 4);
    check("async_reset_tick", frame_tick, 0);
    cycles(2);
    rst = 1'b0;
    cycles(17);
    check("post_reset_hold_x", pos_x, 304);
    wait_tick();
    check("post_reset_x", pos_x, 308);
    btn[3] = 1'b0;

    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 39) == 0) btn[b] = ~btn[b];
    end
    btn = '0;
    cycles(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
